// File: rtl/arriskv_decoder.sv
// ============================================================================
// Module      : arriskv_decoder
// Description : Registered RV32I/RV64I decode stage with an output FIFO.
//               Define ARRISKV_MEXT_EN to accept M-extension OP encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arriskv_decoder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [31:0]                in_instr_i,
    input  logic [XLEN-1:0]            in_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [2:0]                 out_type_o,
    output logic [3:0]                 out_opcode_o,
    output logic [4:0]                 out_rs1_o,
    output logic [4:0]                 out_rs2_o,
    output logic [4:0]                 out_rd_o,
    output logic [2:0]                 out_funct3_o,
    output logic [6:0]                 out_funct7_o,
    output logic [XLEN-1:0]            out_imm_o,
    output logic                       out_illegal_o,
    output logic                       out_mext_o,
    output logic [$clog2(DEPTH+1)-1:0] out_count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    localparam logic [2:0] c_type_r = 3'd0;
    localparam logic [2:0] c_type_i = 3'd1;
    localparam logic [2:0] c_type_s = 3'd2;
    localparam logic [2:0] c_type_b = 3'd3;
    localparam logic [2:0] c_type_u = 3'd4;
    localparam logic [2:0] c_type_j = 3'd5;

    localparam logic [3:0] c_cls_op_imm   = 4'd0;
    localparam logic [3:0] c_cls_op       = 4'd1;
    localparam logic [3:0] c_cls_jal      = 4'd2;
    localparam logic [3:0] c_cls_jalr     = 4'd3;
    localparam logic [3:0] c_cls_branch   = 4'd4;
    localparam logic [3:0] c_cls_load     = 4'd5;
    localparam logic [3:0] c_cls_store    = 4'd6;
    localparam logic [3:0] c_cls_misc_mem = 4'd7;
    localparam logic [3:0] c_cls_system   = 4'd8;
    localparam logic [3:0] c_cls_nop      = 4'd9;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      typ;
        logic [3:0]      opc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
        logic            mext;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;

    entry_t               w_dec;
    entry_t               w_out;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_illegal;
    logic                 w_mext;
    logic [2:0]           w_type;
    logic [3:0]           w_opc;
    logic [31:0]          w_imm32;

    assign out_valid_o = (r_count != '0);
    assign in_ready_o  = rst_n && !flush_i && (r_count < c_depth);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    always_comb begin
        w_illegal = 1'b0;
        w_mext    = 1'b0;
        w_type    = c_type_i;
        w_opc     = c_cls_nop;
        w_imm32   = '0;
        w_dec     = '0;

        case (in_instr_i[6:0])
            7'b0010011: begin w_type = c_type_i; w_opc = c_cls_op_imm;   end
            7'b0110111,
            7'b0010111: begin w_type = c_type_u; w_opc = c_cls_op_imm;   end
            7'b1101111: begin w_type = c_type_j; w_opc = c_cls_jal;      end
            7'b1100011: begin w_type = c_type_b; w_opc = c_cls_branch;   end
            7'b0000011: begin w_type = c_type_i; w_opc = c_cls_load;     end
            7'b0100011: begin w_type = c_type_s; w_opc = c_cls_store;    end
            7'b0001111: begin w_type = c_type_i; w_opc = c_cls_misc_mem; end
            7'b1110011: begin w_type = c_type_i; w_opc = c_cls_system;   end
            7'b1100111: begin
                w_type    = c_type_i;
                w_opc     = c_cls_jalr;
                w_illegal = (in_instr_i[14:12] != 3'b000);
            end
            7'b0110011: begin
                w_type = c_type_r;
                w_opc  = c_cls_op;
                if (in_instr_i[31:25] != 7'h00 && in_instr_i[31:25] != 7'h20) begin
                    if (in_instr_i[31:25] == 7'h01) begin
`ifdef ARRISKV_MEXT_EN
                        w_mext    = 1'b1;
`else
                        w_illegal = 1'b1;
`endif
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            default: w_illegal = 1'b1;
        endcase

        case (w_type)
            c_type_i: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
            c_type_s: w_imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
            c_type_b: w_imm32 = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7],
                                 in_instr_i[30:25], in_instr_i[11:8], 1'b0};
            c_type_u: w_imm32 = {in_instr_i[31:12], 12'b0};
            c_type_j: w_imm32 = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12],
                                 in_instr_i[20], in_instr_i[30:21], 1'b0};
            default:  w_imm32 = '0;
        endcase

        w_dec.pc      = in_pc_i;
        w_dec.funct3  = in_instr_i[14:12];
        w_dec.funct7  = in_instr_i[31:25];
        w_dec.illegal = w_illegal;
        // Illegal beats collapse to a NOP with no register or immediate payload.
        if (!w_illegal) begin
            w_dec.typ  = w_type;
            w_dec.opc  = w_opc;
            w_dec.mext = w_mext;
            w_dec.imm  = XLEN'($signed(w_imm32));
            w_dec.rd   = (w_type == c_type_s || w_type == c_type_b) ? 5'd0 : in_instr_i[11:7];
            w_dec.rs1  = (w_type == c_type_u || w_type == c_type_j) ? 5'd0 : in_instr_i[19:15];
            w_dec.rs2  = (w_type == c_type_r || w_type == c_type_s || w_type == c_type_b)
                         ? in_instr_i[24:20] : 5'd0;
        end else begin
            w_dec.typ  = c_type_i;
            w_dec.opc  = c_cls_nop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            if (w_push && !w_pop)      r_count <= r_count + c_cnt_one;
            else if (w_pop && !w_push) r_count <= r_count - c_cnt_one;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_out         = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign out_pc_o      = w_out.pc;
    assign out_type_o    = w_out.typ;
    assign out_opcode_o  = w_out.opc;
    assign out_rs1_o     = w_out.rs1;
    assign out_rs2_o     = w_out.rs2;
    assign out_rd_o      = w_out.rd;
    assign out_funct3_o  = w_out.funct3;
    assign out_funct7_o  = w_out.funct7;
    assign out_imm_o     = w_out.imm;
    assign out_illegal_o = w_out.illegal;
    assign out_mext_o    = w_out.mext;
    assign out_count_o   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_arriskv_decoder.sv
// ============================================================================
// Module      : tb_arriskv_decoder
// Description : Randomized bench for arriskv_decoder with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arriskv_decoder;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [31:0]     in_instr_i = '0;
    logic [XLEN-1:0] in_pc_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [XLEN-1:0] out_pc_o;
    logic [2:0]      out_type_o;
    logic [3:0]      out_opcode_o;
    logic [4:0]      out_rs1_o;
    logic [4:0]      out_rs2_o;
    logic [4:0]      out_rd_o;
    logic [2:0]      out_funct3_o;
    logic [6:0]      out_funct7_o;
    logic [XLEN-1:0] out_imm_o;
    logic            out_illegal_o;
    logic            out_mext_o;
    logic [CW-1:0]   out_count_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    typedef struct {
        int          typ;
        int          opc;
        int          rs1;
        int          rs2;
        int          rd;
        int          f3;
        int          f7;
        logic [63:0] imm;
        bit          ill;
        bit          mext;
        logic [63:0] pc;
    } exp_t;

    exp_t q[$];

    arriskv_decoder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_type_o(out_type_o), .out_opcode_o(out_opcode_o),
        .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
        .out_funct3_o(out_funct3_o), .out_funct7_o(out_funct7_o),
        .out_imm_o(out_imm_o), .out_illegal_o(out_illegal_o),
        .out_mext_o(out_mext_o), .out_count_o(out_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: field extraction with signed arithmetic on a 64-bit word.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e;
        longint s;
        s      = longint'(signed'(w));
        e.pc   = pc;
        e.f3   = int'(w[14:12]);
        e.f7   = int'(w[31:25]);
        e.ill  = 1'b0;
        e.mext = 1'b0;
        e.typ  = 1;
        e.opc  = 9;
        case (w[6:0])
            7'h13:        begin e.typ = 1; e.opc = 0; end
            7'h37, 7'h17: begin e.typ = 4; e.opc = 0; end
            7'h33: begin
                e.typ = 0; e.opc = 1;
                if (e.f7 == 1) begin
`ifdef ARRISKV_MEXT_EN
                    e.mext = 1'b1;
`else
                    e.ill = 1'b1;
`endif
                end else if (e.f7 != 0 && e.f7 != 32) e.ill = 1'b1;
            end
            7'h6F: begin e.typ = 5; e.opc = 2; end
            7'h67: begin e.typ = 1; e.opc = 3; e.ill = (e.f3 != 0); end
            7'h63: begin e.typ = 3; e.opc = 4; end
            7'h03: begin e.typ = 1; e.opc = 5; end
            7'h23: begin e.typ = 2; e.opc = 6; end
            7'h0F: begin e.typ = 1; e.opc = 7; end
            7'h73: begin e.typ = 1; e.opc = 8; end
            default: e.ill = 1'b1;
        endcase
        case (e.typ)
            1: e.imm = s >>> 20;
            2: e.imm = (s >>> 25) * 32 + longint'(w[11:7]);
            3: e.imm = (s >>> 31) * 4096 + longint'(w[7]) * 2048
                       + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            4: e.imm = (s >>> 12) * 4096;
            5: e.imm = (s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                       + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
            default: e.imm = '0;
        endcase
        e.rd  = (e.typ == 2 || e.typ == 3) ? 0 : int'(w[11:7]);
        e.rs1 = (e.typ == 4 || e.typ == 5) ? 0 : int'(w[19:15]);
        e.rs2 = (e.typ == 0 || e.typ == 2 || e.typ == 3) ? int'(w[24:20]) : 0;
        if (e.ill) begin
            e.typ = 1; e.opc = 9; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
            e.imm = '0; e.mext = 1'b0;
        end
        return e;
    endfunction

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            bit push, pop;
            push = in_valid_i && !flush_i && (q.size() < DEPTH);
            pop  = (q.size() > 0) && out_ready_i;
            if (flush_i) q.delete();
            else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(model(in_instr_i, in_pc_i));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && run) begin
            chk("in_ready", in_ready_o, !flush_i && (q.size() < DEPTH));
            chk("count", out_count_o, q.size());
            chk("out_valid", out_valid_o, q.size() > 0);
            if (q.size() > 0) begin
                chk("pc", out_pc_o, q[0].pc);
                chk("type", out_type_o, q[0].typ);
                chk("opcode", out_opcode_o, q[0].opc);
                chk("rs1", out_rs1_o, q[0].rs1);
                chk("rs2", out_rs2_o, q[0].rs2);
                chk("rd", out_rd_o, q[0].rd);
                chk("funct3", out_funct3_o, q[0].f3);
                chk("funct7", out_funct7_o, q[0].f7);
                chk("imm", out_imm_o, q[0].imm);
                chk("illegal", out_illegal_o, q[0].ill);
                chk("mext", out_mext_o, q[0].mext);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] w, input logic [63:0] pc);
        bit acc;
        int budget;
        budget     = 20;
        in_valid_i = 1'b1;
        in_instr_i = w;
        in_pc_i    = pc;
        do begin
            @(negedge clk);
            acc = in_ready_o;
            step();
            budget--;
        end while (!acc && budget > 0);
        in_valid_i = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic drain();
        int budget;
        budget      = 20;
        out_ready_i = 1'b1;
        while (out_valid_o && budget > 0) begin
            step();
            budget--;
        end
        chk("drain_empty", out_valid_o, 0);
        out_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  ops [11];
        int          k;
        ops = '{7'h13, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
        w   = $urandom;
        k   = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        if (w[6:0] == 7'h67 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        e = model(32'hFFF00093, 64'h0);
        chk("model_addi_imm", e.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        e = model(32'hFE208EE3, 64'h0);
        chk("model_beq_imm", e.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        e = model(32'h123452B7, 64'h0);
        chk("model_lui_imm", e.imm, 64'h1234_5000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_count", out_count_o, 0);
        chk("rst_imm", out_imm_o, 0);
        chk("rst_pc", out_pc_o, 0);
        step();
        rst_n = 1'b1;
        run   = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready_o, 1);

        // addi x1,x0,-1
        push_beat(32'hFFF00093, 64'h1000);
        chk("addi_valid", out_valid_o, 1);
        chk("addi_type", out_type_o, 1);
        chk("addi_opc", out_opcode_o, 0);
        chk("addi_rd", out_rd_o, 1);
        chk("addi_rs1", out_rs1_o, 0);
        chk("addi_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // lui x5,0x12345
        push_beat(32'h123452B7, 64'h1004);
        chk("lui_type", out_type_o, 4);
        chk("lui_opc", out_opcode_o, 0);
        chk("lui_rd", out_rd_o, 5);
        chk("lui_imm", out_imm_o, 64'h1234_5000);
        drain();

        // beq x1,x2,-4
        push_beat(32'hFE208EE3, 64'h1008);
        chk("beq_type", out_type_o, 3);
        chk("beq_opc", out_opcode_o, 4);
        chk("beq_rs1", out_rs1_o, 1);
        chk("beq_rs2", out_rs2_o, 2);
        chk("beq_rd", out_rd_o, 0);
        chk("beq_imm", out_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
        drain();

        // mul x3,x1,x2
        push_beat(32'h022081B3, 64'h100C);
`ifdef ARRISKV_MEXT_EN
        chk("mul_mext", out_mext_o, 1);
        chk("mul_illegal", out_illegal_o, 0);
        chk("mul_rd", out_rd_o, 3);
        chk("mul_opc", out_opcode_o, 1);
`else
        chk("mul_mext", out_mext_o, 0);
        chk("mul_illegal", out_illegal_o, 1);
        chk("mul_opc", out_opcode_o, 9);
        chk("mul_rd", out_rd_o, 0);
`endif
        drain();

        // Backpressure: third beat must wait for a free slot.
        push_beat(32'h00A00513, 64'h2000);
        push_beat(32'h00B00593, 64'h2004);
        in_valid_i = 1'b1;
        in_instr_i = 32'h00C00613;
        in_pc_i    = 64'h2008;
        @(negedge clk);
        chk("full_in_ready", in_ready_o, 0);
        chk("full_count", out_count_o, 2);
        step();
        chk("held_count", out_count_o, 2);
        chk("held_pc", out_pc_o, 64'h2000);
        out_ready_i = 1'b1;
        step();
        chk("second_pc", out_pc_o, 64'h2004);
        push_beat(32'h00C00613, 64'h2008);
        chk("third_pc", out_pc_o, 64'h2008);
        drain();

        // Flush with a simultaneous beat and pop.
        push_beat(32'h00100093, 64'h3000);
        push_beat(32'h00200113, 64'h3004);
        chk("pre_flush_count", out_count_o, 2);
        flush_i     = 1'b1;
        in_valid_i  = 1'b1;
        in_instr_i  = 32'h00300193;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready_o, 0);
        step();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("flush_count", out_count_o, 0);
        chk("flush_valid", out_valid_o, 0);
        step();
        chk("flush_dropped", out_count_o, 0);

        // Asynchronous reset in the middle of a push.
        push_beat(32'h00400213, 64'h4000);
        in_valid_i = 1'b1;
        in_instr_i = 32'h00500293;
        in_pc_i    = 64'h4004;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_count", out_count_o, 0);
        chk("arst_in_ready", in_ready_o, 0);
        chk("arst_pc", out_pc_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        in_valid_i = 1'b0;
        drain();

        for (int i = 0; i < 800; i++) begin
            in_valid_i  = ($urandom_range(0, 9) < 7);
            in_instr_i  = gen_instr();
            in_pc_i     = {$urandom, $urandom};
            out_ready_i = ($urandom_range(0, 9) < 6);
            flush_i     = ($urandom_range(0, 29) == 0);
            step();
        end
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
